// File: rtl/transit_pkg.sv
// Shared types for the transport/bus/train window sequencer.
package transit_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef logic [CNT_W_DEF+1:0] cnt_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] pre;
    logic [CNT_W_DEF-1:0] bus_len;
    logic [CNT_W_DEF-1:0] skew;
    logic [CNT_W_DEF-1:0] train_len;
    logic [CNT_W_DEF-1:0] post;
  } cfg_t;

  // Total run length T = pre + max(bus_len, skew + train_len) + post.
  function automatic cnt_t run_len(input cfg_t c);
    cnt_t b;
    cnt_t st;
    cnt_t e;
    b  = cnt_t'(c.bus_len);
    st = cnt_t'(c.skew) + cnt_t'(c.train_len);
    e  = (b > st) ? b : st;
    return cnt_t'(c.pre) + e + cnt_t'(c.post);
  endfunction

endpackage

// File: rtl/transit_window.sv
// Registered window level: high when t falls inside [start, start+len).
module transit_window
  import transit_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] t,
  input  logic [W-1:0] start,
  input  logic [W-1:0] len,
  output logic         level
);

  logic level_d, level_q;

  always_comb begin
    level_d = en && (t >= start) && (t < start + len);
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: rtl/transit_window_gen.sv
// Sequencer producing nested transport/bus/train windows plus a predicted match strobe.
module transit_window_gen
  import transit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_pre,
  input  logic [CNT_W-1:0] cfg_bus_len,
  input  logic [CNT_W-1:0] cfg_skew,
  input  logic [CNT_W-1:0] cfg_train_len,
  input  logic [CNT_W-1:0] cfg_post,
  output logic             transport,
  output logic             bus,
  output logic             train,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             match_exp,
  output logic [15:0]      run_cnt
);

  if (CNT_W != CNT_W_DEF) begin : g_bad_width
    $error("transit_window_gen: CNT_W must equal transit_pkg::CNT_W_DEF");
  end

  state_e      state_q, state_d;
  cnt_t        t_q, t_d;
  cfg_t        cfg_q, cfg_d, cfg_in;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        match_q, match_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic        win_en;

  assign cfg_in = '{pre: cfg_pre, bus_len: cfg_bus_len, skew: cfg_skew,
                    train_len: cfg_train_len, post: cfg_post};

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    cfg_d     = cfg_q;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_d   = cfg_in;
          t_d     = '0;
          state_d = (run_len(cfg_in) == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (t_q == run_len(cfg_q) - cnt_t'(1)) begin
          state_d = StDone;
        end else begin
          t_d = t_q + cnt_t'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with t_q.
  always_comb begin
    win_en    = (state_d == StRun);
    busy_d    = win_en;
    done_d    = (state_d == StDone);
    match_d   = win_en && (cfg_d.skew == '0) && (cfg_d.bus_len == cfg_d.train_len) &&
                (cfg_d.bus_len != '0) &&
                (t_d == cnt_t'(cfg_d.pre) + cnt_t'(cfg_d.bus_len) - cnt_t'(1));
    run_cnt_d = (done_d && run_cnt_q != 16'hFFFF) ? run_cnt_q + 16'd1 : run_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      cfg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      match_q   <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      cfg_q     <= cfg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      match_q   <= match_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  transit_window u_transport (
    .clk   (clk),
    .rst   (rst),
    .en    (win_en),
    .t     (t_d),
    .start ('0),
    .len   (run_len(cfg_d)),
    .level (transport)
  );

  transit_window u_bus (
    .clk   (clk),
    .rst   (rst),
    .en    (win_en),
    .t     (t_d),
    .start (cnt_t'(cfg_d.pre)),
    .len   (cnt_t'(cfg_d.bus_len)),
    .level (bus)
  );

  transit_window u_train (
    .clk   (clk),
    .rst   (rst),
    .en    (win_en),
    .t     (t_d),
    .start (cnt_t'(cfg_d.pre) + cnt_t'(cfg_d.skew)),
    .len   (cnt_t'(cfg_d.train_len)),
    .level (train)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign match_exp = match_q;
  assign run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_transit_window_gen.sv
// Randomized bench for transit_window_gen against a queue-based expected-waveform model.
module tb_transit_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_pre = '0, cfg_bus_len = '0, cfg_skew = '0, cfg_train_len = '0, cfg_post = '0;
  logic        transport, bus, train, busy, done, aborted, match_exp;
  logic [15:0] run_cnt;

  always #5 clk = ~clk;

  transit_window_gen dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_pre       (cfg_pre),
    .cfg_bus_len   (cfg_bus_len),
    .cfg_skew      (cfg_skew),
    .cfg_train_len (cfg_train_len),
    .cfg_post      (cfg_post),
    .transport     (transport),
    .bus           (bus),
    .train         (train),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .match_exp     (match_exp),
    .run_cnt       (run_cnt)
  );

  typedef struct packed {
    logic tr;
    logic bu;
    logic trn;
    logic busy;
    logic done;
    logic abt;
    logic mat;
  } exp_t;

  exp_t        cur;
  exp_t        q[$];
  int unsigned exp_cnt;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Build the whole expected waveform of one accepted run from the latched config.
  task automatic build_run();
    int p, bl, sk, tl, po, e, tt;
    exp_t x;
    p  = int'(cfg_pre);
    bl = int'(cfg_bus_len);
    sk = int'(cfg_skew);
    tl = int'(cfg_train_len);
    po = int'(cfg_post);
    e  = (bl > sk + tl) ? bl : sk + tl;
    tt = p + e + po;
    for (int t = 0; t < tt; t++) begin
      x      = '0;
      x.tr   = 1'b1;
      x.busy = 1'b1;
      x.bu   = (t >= p) && (t < p + bl);
      x.trn  = (t >= p + sk) && (t < p + sk + tl);
      x.mat  = (sk == 0) && (bl == tl) && (bl != 0) && (t == p + bl - 1);
      q.push_back(x);
    end
    x      = '0;
    x.done = 1'b1;
    q.push_back(x);
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      cur     = '0;
      exp_cnt = 0;
    end else if (cur.busy && abort) begin
      q.delete();
      cur     = '0;
      cur.abt = 1'b1;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (!cur.busy && !cur.done && start) begin
      build_run();
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
    if (!rst && cur.done && exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("transport", {31'd0, transport}, {31'd0, cur.tr});
    check_eq("bus", {31'd0, bus}, {31'd0, cur.bu});
    check_eq("train", {31'd0, train}, {31'd0, cur.trn});
    check_eq("busy", {31'd0, busy}, {31'd0, cur.busy});
    check_eq("done", {31'd0, done}, {31'd0, cur.done});
    check_eq("aborted", {31'd0, aborted}, {31'd0, cur.abt});
    check_eq("match_exp", {31'd0, match_exp}, {31'd0, cur.mat});
    check_eq("run_cnt", {16'd0, run_cnt}, exp_cnt);
  endtask

  task automatic set_cfg(input int p, input int b, input int s, input int t, input int o);
    cfg_pre       = 8'(p);
    cfg_bus_len   = 8'(b);
    cfg_skew      = 8'(s);
    cfg_train_len = 8'(t);
    cfg_post      = 8'(o);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic launch();
    start = 1'b1;
    abort = 1'b0;
    rst   = 1'b0;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    cur     = '0;
    exp_cnt = 0;
    rst     = 1'b1;
    repeat (2) cycle();

    set_cfg(2, 3, 0, 3, 1);
    launch();
    idle(9);

    set_cfg(1, 4, 1, 2, 0);
    launch();
    idle(7);

    set_cfg(0, 0, 0, 0, 0);
    launch();
    idle(3);

    // Abort during t2 of a full-overlap run.
    set_cfg(0, 5, 0, 5, 0);
    launch();
    idle(2);
    abort = 1'b1;
    cycle();
    idle(3);

    // Start held and bus length changed while running.
    set_cfg(1, 2, 0, 2, 1);
    launch();
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_bus_len = 8'($urandom_range(0, 7));
      cycle();
    end
    idle(4);

    // Reset at t3 of a 10-cycle run, then a normal run.
    set_cfg(3, 4, 0, 2, 3);
    launch();
    idle(3);
    rst = 1'b1;
    cycle();
    launch();
    idle(12);

    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) begin
        cfg_pre       = 8'($urandom_range(0, 3));
        cfg_bus_len   = 8'($urandom_range(0, 4));
        cfg_skew      = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(0, 3));
        cfg_train_len = ($urandom_range(0, 1) == 1) ? cfg_bus_len : 8'($urandom_range(0, 4));
        cfg_post      = 8'($urandom_range(0, 2));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
